// File: rtl/sevenseg_scan_decoder.sv
// Watches a multiplexed 4-digit seven-segment bus, decodes each settled digit and assembles
// frames. It reports the displayed 16-bit value with valid, error and stale flags.
module sevenseg_scan_decoder #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        ff,
  input  logic        g,
  input  logic        dp,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  dots,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        stale
);

  localparam int unsigned CntW  = $clog2(SETTLE + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  // Sample layout: {an[3:0], a, b, c, d, e, f, g, dp}
  logic [11:0]      pins;
  logic [11:0]      s_q, s_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [3:0]       seen_q, seen_d;
  logic [15:0]      nib_q, nib_d;
  logic [3:0]       dot_q, dot_d;
  logic [3:0]       err_q, err_d;
  logic [15:0]      value_q, value_d;
  logic [3:0]       dots_q, dots_d;
  logic             fv_q, fv_d;
  logic             ferr_q, ferr_d;
  logic             stale_q, stale_d;

  logic       sel_ok;
  logic [1:0] sel_idx;
  logic       stable;
  logic       capture;
  logic [3:0] dec_nib;
  logic       dec_err;
  logic [6:0] lit;

  assign pins = {an, a, b, c, d, e, ff, g, dp};
  assign lit  = ~s_q[7:1];

  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    unique case (s_q[11:8])
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase
  end

  // Lit segments as {a,b,c,d,e,f,g}
  always_comb begin
    dec_nib = 4'h0;
    dec_err = 1'b0;
    case (lit)
      7'h7E: dec_nib = 4'h0;
      7'h30: dec_nib = 4'h1;
      7'h6D: dec_nib = 4'h2;
      7'h79: dec_nib = 4'h3;
      7'h33: dec_nib = 4'h4;
      7'h5B: dec_nib = 4'h5;
      7'h5F: dec_nib = 4'h6;
      7'h70: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h7B: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h1F: dec_nib = 4'hB;
      7'h4E: dec_nib = 4'hC;
      7'h3D: dec_nib = 4'hD;
      7'h4F: dec_nib = 4'hE;
      7'h47: dec_nib = 4'hF;
      default: dec_err = 1'b1;
    endcase
  end

  // Stability is judged on the sample about to be loaded versus the one held, so a pattern
  // first sampled on edge t reaches SETTLE (and is captured) on edge t+SETTLE.
  assign stable  = sel_ok && (pins == s_q);
  assign capture = stable && (cnt_q == CntW'(SETTLE - 1));

  always_comb begin
    s_d     = pins;
    cnt_d   = '0;
    idle_d  = idle_q;
    seen_d  = seen_q;
    nib_d   = nib_q;
    dot_d   = dot_q;
    err_d   = err_q;
    value_d = value_q;
    dots_d  = dots_q;
    fv_d    = 1'b0;
    ferr_d  = ferr_q;
    stale_d = stale_q;

    if (stable) begin
      cnt_d = (cnt_q == CntW'(SETTLE)) ? cnt_q : cnt_q + CntW'(1);
    end

    if (capture) begin
      idle_d                = '0;
      nib_d[sel_idx*4 +: 4] = dec_nib;
      dot_d[sel_idx]        = ~s_q[0];
      err_d[sel_idx]        = dec_err;
      seen_d[sel_idx]       = 1'b1;
      if (seen_d == 4'hF) begin
        value_d = nib_d;
        dots_d  = dot_d;
        ferr_d  = |err_d;
        fv_d    = 1'b1;
        stale_d = 1'b0;
        seen_d  = 4'h0;
        err_d   = 4'h0;
      end
    end else if (idle_q != IdleW'(TIMEOUT)) begin
      idle_d = idle_q + IdleW'(1);
      if (idle_q == IdleW'(TIMEOUT - 1)) begin
        seen_d  = 4'h0;
        err_d   = 4'h0;
        stale_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_q     <= '1;
      cnt_q   <= '0;
      idle_q  <= '0;
      seen_q  <= '0;
      nib_q   <= '0;
      dot_q   <= '0;
      err_q   <= '0;
      value_q <= '0;
      dots_q  <= '0;
      fv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      seen_q  <= seen_d;
      nib_q   <= nib_d;
      dot_q   <= dot_d;
      err_q   <= err_d;
      value_q <= value_d;
      dots_q  <= dots_d;
      fv_q    <= fv_d;
      ferr_q  <= ferr_d;
      stale_q <= stale_d;
    end
  end

  assign value       = value_q;
  assign dots        = dots_q;
  assign frame_valid = fv_q;
  assign frame_err   = ferr_q;
  assign stale       = stale_q;

endmodule
